// File: rtl/intdivr4_iter_pkg.sv
// Shared definitions for the iterative radix-4 integer divider:
// controller state encoding and the DIV/DIVU/REM/REMU function codes.
package intdivr4_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] FUNCT_DIV  = 2'b00;
    localparam logic [1:0] FUNCT_DIVU = 2'b01;
    localparam logic [1:0] FUNCT_REM  = 2'b10;
    localparam logic [1:0] FUNCT_REMU = 2'b11;

endpackage

// File: rtl/intdivr4_iter_if.sv
// Request/response bundle between the execute stage and the divider.
//
// Handshake: the requester raises Start together with Funct/X/Y; the divider
// takes the request on a rising edge only while it is idle and Flush is low,
// otherwise Start is simply ignored (there is no ready/back-pressure, the
// requester watches Busy/Done). Done is a single-cycle pulse during which
// Result is valid; Result then stays stable until the next accepted Start.
// Flush aborts an operation in progress and suppresses a pending Done.
interface intdivr4_iter_if #(
    parameter int XLEN = 64
);
    logic            Start;
    logic            Flush;
    logic [1:0]      Funct;
    logic [XLEN-1:0] X;
    logic [XLEN-1:0] Y;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, Flush, Funct, X, Y,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Flush, Funct, X, Y,
        output Busy, Done, Result
    );
endinterface

// File: rtl/intdivr4_digit.sv
// One radix-4 restoring digit step: shift two dividend bits into the partial
// remainder and subtract the largest multiple of the divisor that fits.
module intdivr4_digit #(
    parameter int XLEN = 64
) (
    input  logic [XLEN+1:0] r,
    input  logic [1:0]      bits,
    input  logic [XLEN+1:0] d1,
    input  logic [XLEN+1:0] d2,
    input  logic [XLEN+1:0] d3,
    output logic [XLEN+1:0] r_next,
    output logic [1:0]      q
);
    // r < D <= 2^XLEN, so the low XLEN bits carry the whole partial remainder.
    logic [XLEN+1:0] p;
    assign p = {XLEN'(r), bits};

    // Pick the digit by comparing against 3D, 2D, D in that order.
    always_comb begin
        q      = 2'd0;
        r_next = p;
        if (p >= d3) begin
            q      = 2'd3;
            r_next = p - d3;
        end else if (p >= d2) begin
            q      = 2'd2;
            r_next = p - d2;
        end else if (p >= d1) begin
            q      = 2'd1;
            r_next = p - d1;
        end
    end
endmodule

// File: rtl/intdivr4_iter.sv
// Iterative radix-4 restoring divider for DIV/DIVU/REM/REMU. STAGES digit
// steps are chained per clock; divide-by-zero and signed overflow bypass the
// iteration and complete the cycle after Start.
module intdivr4_iter
    import intdivr4_iter_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    intdivr4_iter_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam int N  = XLEN / (2 * STAGES);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(N - 1);
    localparam logic [1:0]      S_IDLE   = IDLE;
    localparam logic [1:0]      S_BUSY   = BUSY;
    localparam logic [1:0]      S_DONE   = DONE;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    if ((XLEN % 2) != 0 || ((XLEN / 2) % STAGES) != 0) begin : g_bad_params
        $error("intdivr4_iter: XLEN must be even and (XLEN/2) divisible by STAGES");
    end

    logic [1:0]      state;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] dvd;
    logic [XLEN+1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN+1:0] d1, d2, d3;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] result_r;

    logic            signed_op, rem_op, x_neg, y_neg, special, accept;
    logic [XLEN-1:0] x_abs, y_abs, special_res;
    logic [XLEN+1:0] y_ext, d2_init, d3_init;

    // Operand conditioning for a new request: magnitudes, divisor multiples
    // and the short-circuit result for divide-by-zero / signed overflow.
    always_comb begin
        signed_op   = (bus.Funct == FUNCT_DIV) || (bus.Funct == FUNCT_REM);
        rem_op      = (bus.Funct == FUNCT_REM) || (bus.Funct == FUNCT_REMU);
        x_neg       = signed_op & bus.X[XLEN-1];
        y_neg       = signed_op & bus.Y[XLEN-1];
        x_abs       = x_neg ? -bus.X : bus.X;
        y_abs       = y_neg ? -bus.Y : bus.Y;
        y_ext       = {2'b00, y_abs};
        d2_init     = y_ext << 1;
        d3_init     = y_ext + d2_init;
        special     = 1'b0;
        special_res = '0;
        if (bus.Y == '0) begin
            special     = 1'b1;
            special_res = rem_op ? bus.X : '1;
        end else if (signed_op && bus.X == MOST_NEG && bus.Y == '1) begin
            special     = 1'b1;
            special_res = rem_op ? '0 : bus.X;
        end
        accept = (state == S_IDLE) & bus.Start & ~bus.Flush;
    end

    // Unrolled digit chain; stage 0 consumes the most significant bit pair.
    logic [2*STAGES-1:0] digits;
    logic [XLEN+1:0]     r_final;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [XLEN+1:0] r_in;
        logic [XLEN+1:0] r_out;
        logic [1:0]      q_dig;
        if (s == 0) begin : g_first
            assign r_in = rem_r;
        end else begin : g_next
            assign r_in = g_stage[s-1].r_out;
        end
        intdivr4_digit #(.XLEN(XLEN)) u_digit (
            .r      (r_in),
            .bits   (dvd[XLEN-1-2*s -: 2]),
            .d1     (d1),
            .d2     (d2),
            .d3     (d3),
            .r_next (r_out),
            .q      (q_dig)
        );
        assign digits[2*(STAGES-s)-1 -: 2] = q_dig;
    end
    assign r_final = g_stage[STAGES-1].r_out;

    logic [XLEN-1:0] q_next, dvd_next, rem_mag, busy_res;

    // Next quotient/dividend after this cycle's digits, then sign fixup so
    // the result is ready to register on the final BUSY cycle.
    always_comb begin
        q_next   = XLEN'({quo_r, digits});
        dvd_next = dvd << (2 * STAGES);
        rem_mag  = XLEN'(r_final);
        if (is_rem)
            busy_res = neg_r ? -rem_mag : rem_mag;
        else
            busy_res = neg_q ? -q_next : q_next;
    end

    // Controller and datapath registers; Flush drops back to IDLE without
    // touching Result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvd      <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_rem <= rem_op;
                        neg_q  <= x_neg ^ y_neg;
                        neg_r  <= x_neg;
                        dvd    <= x_abs;
                        rem_r  <= '0;
                        quo_r  <= '0;
                        d1     <= y_ext;
                        d2     <= d2_init;
                        d3     <= d3_init;
                        cnt    <= CNT_INIT;
                        if (special) begin
                            state    <= S_DONE;
                            result_r <= special_res;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.Flush) begin
                        state <= S_IDLE;
                    end else begin
                        dvd   <= dvd_next;
                        rem_r <= r_final;
                        quo_r <= q_next;
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state    <= S_DONE;
                            result_r <= busy_res;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy   = (state == S_BUSY);
    assign bus.Done   = (state == S_DONE) & ~bus.Flush;
    assign bus.Result = result_r;
    assign dbg_state  = state;
endmodule

// File: tb/tb_intdivr4_iter.sv
// Self-checking bench for intdivr4_iter: three instances (32/1, 64/4, 64/2
// digits per clock) exercised with directed cases and random operations
// compared against a plain-arithmetic divide model.
module tb_intdivr4_iter;
    import intdivr4_iter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    intdivr4_iter_if #(.XLEN(32)) bus_a ();
    intdivr4_iter_if #(.XLEN(64)) bus_b ();
    intdivr4_iter_if #(.XLEN(64)) bus_c ();
    logic [1:0] dbg_a, dbg_b, dbg_c;

    intdivr4_iter #(.XLEN(32), .STAGES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a));
    intdivr4_iter #(.XLEN(64), .STAGES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b));
    intdivr4_iter #(.XLEN(64), .STAGES(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(bus_c), .dbg_state(dbg_c));

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- per-instance access ----------------
    function automatic int xlen_of(input int w);
        return (w == 0) ? 32 : 64;
    endfunction

    function automatic int stages_of(input int w);
        case (w)
            0:       return 1;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic fl, input logic [1:0] f,
                         input logic [63:0] x, input logic [63:0] y);
        case (w)
            0: begin bus_a.Start = st; bus_a.Flush = fl; bus_a.Funct = f; bus_a.X = x[31:0]; bus_a.Y = y[31:0]; end
            1: begin bus_b.Start = st; bus_b.Flush = fl; bus_b.Funct = f; bus_b.X = x; bus_b.Y = y; end
            default: begin bus_c.Start = st; bus_c.Flush = fl; bus_c.Funct = f; bus_c.X = x; bus_c.Y = y; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            0:       return bus_a.Busy;
            1:       return bus_b.Busy;
            default: return bus_c.Busy;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0:       return bus_a.Done;
            1:       return bus_b.Done;
            default: return bus_c.Done;
        endcase
    endfunction

    function automatic logic [63:0] get_result(input int w);
        case (w)
            0:       return 64'(bus_a.Result);
            1:       return bus_b.Result;
            default: return bus_c.Result;
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask_of(input int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic is_special(input int xlen, input logic [1:0] f,
                                        input logic [63:0] x, input logic [63:0] y);
        logic [63:0] minv;
        minv = 64'd1 << (xlen - 1);
        return (y == 64'd0) || (!f[0] && x == minv && y == mask_of(xlen));
    endfunction

    function automatic logic [63:0] ref_model(input int xlen, input logic [1:0] f,
                                              input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask, minv, r;
        longint sx, sy;
        mask = mask_of(xlen);
        minv = 64'd1 << (xlen - 1);
        if (xlen == 32) begin
            sx = longint'($signed(x[31:0]));
            sy = longint'($signed(y[31:0]));
        end else begin
            sx = $signed(x);
            sy = $signed(y);
        end
        if (y == 64'd0)
            r = f[1] ? x : mask;
        else if (!f[0] && x == minv && y == mask)
            r = f[1] ? 64'd0 : x;
        else if (!f[0])
            r = f[1] ? 64'(sx % sy) : 64'(sx / sy);
        else
            r = f[1] ? (x % y) : (x / y);
        return r & mask;
    endfunction

    // ---------------- driver ----------------
    // Issues one op and waits (bounded) for Done. lat counts negedges after
    // the accepting edge, so lat==1 means Done in the cycle right after it.
    task automatic run_op(input int w, input logic [1:0] f, input logic [63:0] x,
                          input logic [63:0] y, output logic [63:0] res,
                          output int lat, output int busy_n);
        res = '0;
        lat = -1;
        busy_n = 0;
        @(negedge clk);
        drive(w, 1'b1, 1'b0, f, x, y);
        @(posedge clk);
        #1 drive(w, 1'b0, 1'b0, f, x, y);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (get_busy(w)) busy_n++;
            if (get_done(w)) begin
                res = get_result(w);
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_op(input int w, input logic [1:0] f, input logic [63:0] x,
                            input logic [63:0] y, input logic [63:0] exp, input string tag);
        logic [63:0] res;
        int lat, busy_n, n_steps;
        n_steps = xlen_of(w) / (2 * stages_of(w));
        run_op(w, f, x, y, res, lat, busy_n);
        check({tag, "_res"}, res, exp);
        if (is_special(xlen_of(w), f, x, y)) begin
            check({tag, "_lat"}, 64'(lat), 64'd1);
            check({tag, "_busy"}, 64'(busy_n), 64'd0);
        end else begin
            check({tag, "_lat"}, 64'(lat), 64'(n_steps + 1));
            check({tag, "_busy"}, 64'(busy_n), 64'(n_steps));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] res, x, y, mask, minv;
        logic [1:0]  f;
        int lat, busy_n, seen_done, seen_busy, xl;

        for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            check("reset_busy", 64'(get_busy(w)), 64'd0);
            check("reset_done", 64'(get_done(w)), 64'd0);
            check("reset_result", get_result(w), 64'd0);
        end
        reset_n = 1'b1;

        // Basic unsigned and signed cases on the 32-bit, one-digit-per-clock unit.
        check_op(0, FUNCT_DIVU, 64'd100, 64'd7, 64'd14, "divu_100_7");
        check_op(0, FUNCT_REMU, 64'd100, 64'd7, 64'd2, "remu_100_7");
        check_op(0, FUNCT_DIV, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "div_m7_2");
        check_op(0, FUNCT_REM, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "rem_m7_2");
        check_op(0, FUNCT_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF, "div_5_0");
        check_op(0, FUNCT_REM, 64'd5, 64'd0, 64'd5, "rem_5_0");
        check_op(0, FUNCT_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "div_ovf");
        check_op(0, FUNCT_REM, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "rem_ovf");
        check_op(1, FUNCT_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, "divu64_ones_3");
        check_op(2, FUNCT_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, "div64s2_m100_7");
        check_op(0, FUNCT_DIVU, 64'd1000, 64'd7, 64'd142, "divu_1000_7");

        // Flush during the 5th BUSY cycle: back to IDLE, no Done, Result kept.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, FUNCT_DIVU, 64'd1000, 64'd3);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, FUNCT_DIVU, 64'd1000, 64'd3);
        repeat (4) @(posedge clk);
        #1 bus_a.Flush = 1'b1;
        @(posedge clk);
        #1 bus_a.Flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(get_busy(0)), 64'd0);
        check("flush_state", 64'(dbg_a), 64'(IDLE));
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (get_done(0)) seen_done++;
        end
        check("flush_no_done", 64'(seen_done), 64'd0);
        check("flush_result", get_result(0), 64'd142);

        // Start together with Flush is not accepted.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, FUNCT_DIVU, 64'd50, 64'd5);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, FUNCT_DIVU, 64'd50, 64'd5);
        seen_done = 0;
        seen_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (get_done(0)) seen_done++;
            if (get_busy(0)) seen_busy++;
        end
        check("startflush_busy", 64'(seen_busy), 64'd0);
        check("startflush_done", 64'(seen_done), 64'd0);
        check("startflush_result", get_result(0), 64'd142);

        // A second Start while BUSY is ignored.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, FUNCT_DIVU, 64'd1000, 64'd3);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, FUNCT_DIVU, 64'd1000, 64'd3);
        lat = -1;
        res = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 4) drive(0, 1'b1, 1'b0, FUNCT_REMU, 64'd77, 64'd7);
            if (c == 5) drive(0, 1'b0, 1'b0, FUNCT_REMU, 64'd77, 64'd7);
            if (get_done(0)) begin
                res = get_result(0);
                lat = c;
                break;
            end
        end
        check("busystart_res", res, 64'd333);
        check("busystart_lat", 64'(lat), 64'd17);

        // Asynchronous reset in the middle of an operation.
        check_op(1, FUNCT_REMU, 64'd1000, 64'd7, 64'd6, "remu64_1000_7");
        @(negedge clk);
        drive(0, 1'b1, 1'b0, FUNCT_DIVU, 64'd1000, 64'd3);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, FUNCT_DIVU, 64'd1000, 64'd3);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(get_busy(0)), 64'd0);
        check("arst_done", 64'(get_done(0)), 64'd0);
        check("arst_result", get_result(0), 64'd0);
        check("arst_result_b", get_result(1), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_op(0, FUNCT_DIVU, 64'd9, 64'd3, 64'd3, "post_reset_divu");

        // Random operations, biased towards boundary operands.
        for (int w = 0; w < 3; w++) begin
            xl   = xlen_of(w);
            mask = mask_of(xl);
            minv = 64'd1 << (xl - 1);
            for (int i = 0; i < 600; i++) begin
                f = 2'($urandom_range(0, 3));
                x = {$urandom, $urandom} & mask;
                y = {$urandom, $urandom} & mask;
                case ($urandom_range(0, 9))
                    0: y = 64'd0;
                    1: begin x = minv; y = mask; end
                    2: y = 64'($urandom_range(1, 15));
                    3: x = 64'($urandom_range(0, 100));
                    4: y = y >> $urandom_range(0, xl - 1);
                    5: x = x | minv;
                    default: ;
                endcase
                run_op(w, f, x, y, res, lat, busy_n);
                check("rand_res", res, ref_model(xl, f, x, y));
                check("rand_lat", 64'(lat),
                      is_special(xl, f, x, y) ? 64'd1 : 64'(xl / (2 * stages_of(w)) + 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so a stuck run still terminates.
    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
